shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl_pkg.sv | 24 ++
 rtl/shift_seq_ctrl_if.sv | 31 +++
 rtl/shift_seq_ctrl_counter.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_pkg
// Description : Shared types and constants for the shift-register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    localparam int c_DEF_N       = 8;
    localparam int c_DEF_CLR_CYC = 2;

    // Serial bit-order encoding for the LSB_FIRST parameter
    localparam bit c_MSB_FIRST = 1'b0;
    localparam bit c_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl_if
// Description : Request/response bundle between a client and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int N = c_DEF_N
);
    logic         start;
    logic [N-1:0] din;
    logic         clr_req;
    logic         ready;
    logic         SID;
    logic         shift_en;
    logic         SR_RS;
    logic         done;

    modport master (
        output start, din, clr_req,
        input  ready, SID, shift_en, SR_RS, done
    );

    modport slave (
        input  start, din, clr_req,
        output ready, SID, shift_en, SR_RS, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Up-counter with sync clear, enable and wrap at a terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_last,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_tc
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_tc    = (r_count == i_last);
    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Serialises a parallel word into, or clears, a downstream shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int N         = c_DEF_N,
    parameter int CLR_CYC   = c_DEF_CLR_CYC,
    parameter bit LSB_FIRST = c_MSB_FIRST
) (
    input  wire logic        Clk,
    input  wire logic        RS,
    shift_seq_ctrl_if.slave  bus
);
    // One counter serves both phases, so it is sized for the longer one
    localparam int c_SPAN = (N > CLR_CYC) ? N : CLR_CYC;
    localparam int c_CW   = (c_SPAN > 1) ? $clog2(c_SPAN) : 1;
    localparam logic [c_CW-1:0] c_SHIFT_LAST = c_CW'(N - 1);
    localparam logic [c_CW-1:0] c_CLEAR_LAST = c_CW'(CLR_CYC - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_shadow;
    logic [N-1:0]    w_shadow_nxt;
    logic            r_sid;
    logic            r_shift_en;
    logic            r_sr_rs;
    logic            r_done;
    logic            w_sid_nxt;
    logic [N-1:0]    w_sel;
    logic [N-1:0]    w_word;
    logic [c_CW-1:0] w_pos;
    logic [c_CW-1:0] w_bit;
    logic [c_CW-1:0] w_cnt;
    logic [c_CW-1:0] w_last;
    logic            w_tc;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    assign w_last    = (r_state == CLEAR) ? c_CLEAR_LAST : c_SHIFT_LAST;
    assign w_cnt_clr = (r_state == IDLE);
    assign w_cnt_en  = (r_state == CLEAR) || (r_state == SHIFT);

    mod_counter #(
        .WIDTH (c_CW)
    ) u_cnt (
        .clk     (Clk),
        .rst     (RS),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_last  (w_last),
        .o_count (w_cnt),
        .o_tc    (w_tc)
    );

    // SID is registered, so each cycle presents the bit for the following shift slot
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_sel        = r_shadow;
        w_pos        = w_cnt + c_CW'(1);
        case (r_state)
            IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = CLEAR;
                end else if (bus.start) begin
                    w_state_nxt  = SHIFT;
                    w_shadow_nxt = bus.din;
                    w_sel        = bus.din;
                    w_pos        = '0;
                end
            end
            CLEAR:   if (w_tc) w_state_nxt = DONE;
            SHIFT:   if (w_tc) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_bit     = (LSB_FIRST == c_LSB_FIRST) ? w_pos : (c_SHIFT_LAST - w_pos);
        w_word    = w_sel >> w_bit;
        w_sid_nxt = (w_state_nxt == SHIFT) && w_word[0];
    end

    always_ff @(posedge Clk) begin
        if (RS) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_sid      <= 1'b0;
            r_shift_en <= 1'b0;
            r_sr_rs    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_sid      <= w_sid_nxt;
            r_shift_en <= (w_state_nxt == SHIFT);
            r_sr_rs    <= (w_state_nxt == CLEAR);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    assign bus.ready    = (r_state == IDLE);
    assign bus.SID      = r_sid;
    assign bus.shift_en = r_shift_en;
    assign bus.SR_RS    = r_sr_rs;
    assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Directed bench driving an MSB-first and an LSB-first sequencer in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;
    import shift_ctrl_pkg::*;

    localparam int c_N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clr_req;
    logic [7:0] din;

    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.N(c_N)) bus_m ();
    shift_seq_ctrl_if #(.N(c_N)) bus_l ();

    assign bus_m.start   = start;
    assign bus_m.clr_req = clr_req;
    assign bus_m.din     = din;
    assign bus_l.start   = start;
    assign bus_l.clr_req = clr_req;
    assign bus_l.din     = din;

    shift_seq_ctrl #(.N(c_N), .CLR_CYC(2), .LSB_FIRST(c_MSB_FIRST)) dut_m (
        .Clk (clk), .RS (rst), .bus (bus_m.slave)
    );
    shift_seq_ctrl #(.N(c_N), .CLR_CYC(2), .LSB_FIRST(c_LSB_FIRST)) dut_l (
        .Clk (clk), .RS (rst), .bus (bus_l.slave)
    );

    // Downstream registers: left-shifting for MSB-first, right-shifting for LSB-first
    logic [7:0] q_m, q_l;
    always @(posedge clk) begin
        if (bus_m.SR_RS)         q_m <= 8'h00;
        else if (bus_m.shift_en) q_m <= {q_m[6:0], bus_m.SID};
        if (bus_l.SR_RS)         q_l <= 8'h00;
        else if (bus_l.shift_en) q_l <= {bus_l.SID, q_l[7:1]};
    end

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] t_sid_m, t_sid_l, t_en_m, t_en_l, t_done_m, t_done_l, t_rdy_m, t_srrs_m, t_srrs_l;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sample();
        t_sid_m  = {t_sid_m[14:0],  bus_m.SID};
        t_sid_l  = {t_sid_l[14:0],  bus_l.SID};
        t_en_m   = {t_en_m[14:0],   bus_m.shift_en};
        t_en_l   = {t_en_l[14:0],   bus_l.shift_en};
        t_done_m = {t_done_m[14:0], bus_m.done};
        t_done_l = {t_done_l[14:0], bus_l.done};
        t_rdy_m  = {t_rdy_m[14:0],  bus_m.ready};
        t_srrs_m = {t_srrs_m[14:0], bus_m.SR_RS};
        t_srrs_l = {t_srrs_l[14:0], bus_l.SR_RS};
    endtask

    // Issue a request, then record ncyc cycles; optionally inject stimulus after cycle inj_cyc
    task automatic run(input int ncyc, input logic st, input logic cr, input logic [7:0] d,
                       input int inj_cyc, input logic inj_st, input logic inj_cr,
                       input logic [7:0] inj_d, input logic inj_rs);
        {t_sid_m, t_sid_l, t_en_m, t_en_l, t_done_m} = '0;
        {t_done_l, t_rdy_m, t_srrs_m, t_srrs_l}      = '0;
        @(negedge clk);
        start = st; clr_req = cr; din = d;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            sample();
            start = 1'b0; clr_req = 1'b0; rst = 1'b0;
            if (c == inj_cyc) begin
                start = inj_st; clr_req = inj_cr; din = inj_d; rst = inj_rs;
            end
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] sid_msb;
        logic [7:0] sid_lsb;
        logic [7:0] q;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[1] = '{8'h01, 8'h01, 8'h80, 8'h01};
        tbl[2] = '{8'hC1, 8'hC1, 8'h83, 8'hC1};
        tbl[3] = '{8'hD4, 8'hD4, 8'h2B, 8'hD4};
        tbl[4] = '{8'h80, 8'h80, 8'h01, 8'h80};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst = 1'b1; start = 1'b0; clr_req = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outs_m", {11'd0, bus_m.ready, bus_m.SID, bus_m.shift_en, bus_m.SR_RS, bus_m.done}, 16'b10000);
        check("reset_outs_l", {11'd0, bus_l.ready, bus_l.SID, bus_l.shift_en, bus_l.SR_RS, bus_l.done}, 16'b10000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {15'd0, bus_m.ready}, 16'd1);

        for (int i = 0; i < 6; i++) begin
            run(10, 1'b1, 1'b0, tbl[i].din, -1, 1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("v%0d_sid_msb", i), t_sid_m, {6'd0, tbl[i].sid_msb, 2'b00});
            check($sformatf("v%0d_sid_lsb", i), t_sid_l, {6'd0, tbl[i].sid_lsb, 2'b00});
            check($sformatf("v%0d_shift_en", i), t_en_m, 16'h03FC);
            check($sformatf("v%0d_shift_en_l", i), t_en_l, 16'h03FC);
            check($sformatf("v%0d_done", i), t_done_m, 16'h0002);
            check($sformatf("v%0d_done_l", i), t_done_l, 16'h0002);
            check($sformatf("v%0d_ready", i), t_rdy_m, 16'h0001);
            check($sformatf("v%0d_sr_rs", i), t_srrs_m, 16'h0000);
            check($sformatf("v%0d_q_msb", i), {8'd0, q_m}, {8'd0, tbl[i].q});
            check($sformatf("v%0d_q_lsb", i), {8'd0, q_l}, {8'd0, tbl[i].q});
        end

        // Clear with the downstream register full of ones (last vector was 8'hFF)
        check("pre_clear_q", {8'd0, q_m}, 16'h00FF);
        run(4, 1'b0, 1'b1, 8'h00, -1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("clr_sr_rs", t_srrs_m, 16'b1100);
        check("clr_sr_rs_l", t_srrs_l, 16'b1100);
        check("clr_done", t_done_m, 16'b0010);
        check("clr_shift_en", t_en_m, 16'b0000);
        check("clr_sid", t_sid_m, 16'b0000);
        check("clr_ready", t_rdy_m, 16'b0001);
        check("clr_q", {8'd0, q_m}, 16'h0000);

        // start and clr_req together: clear wins, start is dropped
        run(10, 1'b1, 1'b0, 8'hA5, -1, 1'b0, 1'b0, 8'h00, 1'b0);
        run(5, 1'b1, 1'b1, 8'h3C, -1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("both_sr_rs", t_srrs_m, 16'b11000);
        check("both_shift_en", t_en_m, 16'b00000);
        check("both_done", t_done_m, 16'b00100);
        check("both_ready", t_rdy_m, 16'b00011);
        check("both_q", {8'd0, q_m}, 16'h0000);

        // New start with different din mid-shift is ignored
        run(10, 1'b1, 1'b0, 8'hA5, 2, 1'b1, 1'b0, 8'h3C, 1'b0);
        check("ign_start_sid", t_sid_m, {6'd0, 8'hA5, 2'b00});
        check("ign_start_en", t_en_m, 16'h03FC);
        check("ign_start_done", t_done_m, 16'h0002);
        check("ign_start_q", {8'd0, q_m}, 16'h00A5);

        // clr_req mid-shift is ignored
        run(10, 1'b1, 1'b0, 8'h5A, 5, 1'b0, 1'b1, 8'h5A, 1'b0);
        check("ign_clr_sr_rs", t_srrs_m, 16'h0000);
        check("ign_clr_q", {8'd0, q_m}, 16'h005A);

        // Reset in shift cycle 4 aborts without a done pulse
        run(8, 1'b1, 1'b0, 8'hA5, 4, 1'b0, 1'b0, 8'hA5, 1'b1);
        check("abort_shift_en", t_en_m, 16'hF8);
        check("abort_sid", t_sid_m, 16'hA0);
        check("abort_sid_l", t_sid_l, 16'hA0);
        check("abort_done", t_done_m, 16'h00);
        check("abort_sr_rs", t_srrs_m, 16'h00);
        check("abort_ready", t_rdy_m, 16'h07);

        run(10, 1'b1, 1'b0, 8'h5A, -1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("after_abort_sid", t_sid_m, {6'd0, 8'h5A, 2'b00});
        check("after_abort_done", t_done_m, 16'h0002);
        check("after_abort_q", {8'd0, q_m}, 16'h005A);
        check("after_abort_q_l", {8'd0, q_l}, 16'h005A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
